// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the parametrised UART receiver.
package uart_pkg;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Parity-mode selector values.
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clocks per oversample tick, rounded to the nearest integer.
    function automatic int uart_div(input int clk_hz, input int baud, input int os);
        longint rate;
        rate = longint'(baud) * longint'(os);
        return int'((longint'(clk_hz) + rate / 2) / rate);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: the head word is visible on rd_data whenever
// the FIFO is non-empty. A push while full is accepted only if a pop happens
// in the same cycle; otherwise the word is dropped and the contents are kept.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    // Gate the head word so the output is a clean zero while empty.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // Accept/advance decisions; pointers wrap naturally at a power-of-2 depth.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; occupancy is
        // tracked by count_q and unread entries are never exposed.
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with a show-ahead receive FIFO and
// one-cycle framing/parity/overrun error pulses.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 66_666_667,
    parameter int BAUD       = 19200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV   = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int DIV_W = $clog2(DIV + 1);
    localparam int TC_W  = $clog2(OVERSAMPLE);
    localparam int HALF  = OVERSAMPLE / 2;
    localparam int CNT_W = $clog2(DATA_BITS + 1);

    // Tick generator.
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 tick;

    // Input synchroniser.
    logic [1:0]           rx_sync_q, rx_sync_d;
    logic                 rxs;

    // Receiver FSM.
    rx_state_e            state_q, state_d;
    logic [TC_W-1:0]      tc_q, tc_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic                 stop_bad_q, stop_bad_d;
    logic                 push_q, push_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 half_tick, mid_tick, stop_bad_now, par_x;

    // FIFO side.
    logic                 fifo_full, fifo_empty;

    assign tick         = (div_q == DIV_W'(DIV - 1));
    assign rxs          = rx_sync_q[1];
    assign half_tick    = tick && (tc_q == TC_W'(HALF - 1));
    assign mid_tick     = tick && (tc_q == TC_W'(OVERSAMPLE - 1));
    assign stop_bad_now = stop_bad_q | ~rxs;
    assign par_x        = (^shift_q) ^ rxs;

    // Free-running divider producing one tick every DIV clocks.
    always_comb begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    // Two-stage shift for the asynchronous rx pin.
    always_comb begin
        rx_sync_d = {rx_sync_q[0], rx};
    end

    // Frame FSM: bit timing, sampling, and frame-completion decisions.
    always_comb begin
        state_d      = state_q;
        tc_d         = tc_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        stop_bad_d   = stop_bad_q;
        push_d       = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;

        if (tick) begin
            tc_d = tc_q + TC_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    tc_d       = '0;
                    bit_cnt_d  = '0;
                    par_bad_d  = 1'b0;
                    stop_bad_d = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                // Re-check the start bit at its midpoint to reject glitches.
                if (half_tick) begin
                    if (rxs) begin
                        state_d = ST_IDLE;
                    end else begin
                        tc_d    = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (mid_tick) begin
                    tc_d    = '0;
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (mid_tick) begin
                    tc_d      = '0;
                    par_bad_d = (PARITY == PAR_ODD)  ? ~par_x :
                                (PARITY == PAR_EVEN) ?  par_x : 1'b0;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (mid_tick) begin
                    tc_d = '0;
                    if (bit_cnt_q == CNT_W'(STOP_BITS - 1)) begin
                        // Leave at the stop midpoint so back-to-back frames work.
                        frame_err_d  = stop_bad_now;
                        parity_err_d = !stop_bad_now && par_bad_q;
                        push_d       = !stop_bad_now && !par_bad_q;
                        state_d      = stop_bad_now ? ST_BREAK : ST_IDLE;
                    end else begin
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                        stop_bad_d = stop_bad_now;
                    end
                end
            end
            ST_BREAK: begin
                // A held-low line yields a single frame error, then waits.
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register stage for divider, synchroniser, FSM and error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q        <= '0;
            rx_sync_q    <= 2'b11;
            state_q      <= ST_IDLE;
            tc_q         <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            stop_bad_q   <= 1'b0;
            push_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            rx_sync_q    <= rx_sync_d;
            state_q      <= state_d;
            tc_q         <= tc_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            stop_bad_q   <= stop_bad_d;
            push_q       <= push_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    // shift_q stays stable until the next frame's first data sample, so it
    // can feed the FIFO directly in the push cycle.
    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push_q),
        .push_data (shift_q),
        .pop       (rx_ready),
        .rd_data   (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rx_valid   = !fifo_empty;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    // A good word is lost only when the FIFO is full and nothing leaves.
    assign overrun    = push_q && fifo_full && !(rx_valid && rx_ready);

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, the next generation of the receive path in `TOP_UART`. It oversamples the serial `rx` line, and supports configurable data width, parity and stop bits. Good frames go into an internal show-ahead FIFO, which is drained through a valid/ready handshake. Framing, parity and overrun errors are reported as one-cycle pulses. The block sits between the board `rx` pin and the consuming logic in place of the fixed 8N1 receiver.

## Interface
- `CLK_FREQ`, 66_666_667: clock frequency in Hz (15 ns period).
- `BAUD`, 19200: line rate in bit/s.
- `OVERSAMPLE`, 16: ticks per bit. Must be even and ≥ 8.
- `DATA_BITS`, 8: payload width, 5 to 9.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `FIFO_DEPTH`, 8: receive FIFO entries. Power of 2, ≥ 2.
- `clk`  input  1  system clock.
- `rst`  input  1  asynchronous, active-low reset.
- `rx`  input  1  serial line, asynchronous, idle high.
- `rx_data`  output  DATA_BITS  FIFO head word.
- `rx_valid`  output  1  FIFO not empty.
- `rx_ready`  input  1  consumer accepts `rx_data` this cycle.
- `frame_err`  output  1  one-cycle pulse: a stop bit was sampled low.
- `parity_err`  output  1  one-cycle pulse: parity mismatch.
- `overrun`  output  1  one-cycle pulse: a good frame was dropped because the FIFO was full.
- `fifo_count`  output  $clog2(FIFO_DEPTH)+1  number of occupied entries.

## Operation
- **Tick generator.** `DIV = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE)`, which is 217 at the defaults. A free-running counter produces a one-clock `tick` every `DIV` clocks.
- **Synchroniser.** `rx` passes through a 2-flop synchroniser; both flops reset to 1. All sampling uses the synchronised value `rxs`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, BREAK. The tick counter `tc` counts ticks within the current bit.
  - IDLE: when `rxs` is 0, clear `tc` and go to START.
  - START: at `tc == OVERSAMPLE/2-1`, sample `rxs`. If it is 1, this is a false start; return to IDLE. If it is 0, clear `tc` and go to DATA.
  - DATA: sample `rxs` every OVERSAMPLE ticks, at mid-bit. Shift the bits in LSB first. After DATA_BITS samples, go to PARITY if `PARITY != 0`, otherwise go to STOP.
  - PARITY: sample the parity bit. Odd mode requires XOR of data and parity bit = 1. Even mode requires XOR = 0. Record the mismatch.
  - STOP: sample STOP_BITS stop bits. On the final stop sample, the actions below happen in the next clock.
- **Frame completion**, evaluated in priority order:
  - If any stop bit sampled 0: pulse `frame_err`, drop the frame, go to BREAK.
  - Else if parity mismatched: pulse `parity_err`, drop the frame, go to IDLE.
  - Else push the word into the FIFO and go to IDLE.
  - Returning to IDLE at the stop-bit mid-point allows back-to-back frames.
- **BREAK:** wait until `rxs` is 1, then go to IDLE. A held-low line therefore produces exactly one `frame_err`.
- **FIFO.** `rx_data` always shows the head word. A pop occurs on `rx_valid && rx_ready`.
  - Push while full without a pop in the same cycle: drop the new word and pulse `overrun`. Stored contents are unchanged.
  - Push and pop in the same cycle while full: both are accepted, no overrun, `fifo_count` unchanged.
  - Pop while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- **Reset values:** `rx_data`=0, `rx_valid`=0, all error pulses 0, `fifo_count`=0. FSM in IDLE, tick counter 0.
- **Reset mid-frame:** the frame is aborted and nothing partial is pushed.
- **Input latency:** 2 clocks from `rx` to `rxs`.
- **Output latency:** the push occurs 1 clock after the final stop-bit sample tick. `rx_valid` rises (or `fifo_count` increments) in the clock after the push.
- **Error pulse timing:** all error pulses assert in the same clock the push would have occurred, and last exactly 1 clock.
- **Bit period** = `DIV*OVERSAMPLE` clocks, which is 3472 at the defaults.
- **Baud tolerance:** frames must decode with up to ±2% baud mismatch.

## Structure
- **Package `uart_pkg`:**
  - FSM state encoding.
  - Parity-mode constants `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`.
  - Divider function `uart_div(clk, baud, os)`.
- **Sub-module `sync_fifo`:** parameters WIDTH and DEPTH. It has show-ahead output, push/pop/full/empty/count signals, and handles simultaneous push and pop at full.
- **Top level:** the tick generator, synchroniser and FSM live in `uart_rx_param` itself.

## Test plan
- **Back-to-back 8N1 frames.** Defaults, `rx_ready`=1. Send 0x30, 0x27 and 0x31 with 5 idle bit times between them. Required: three `rx_valid` handshakes carrying 0x30, 0x27, 0x31, and no error pulses.
- **False start.** Hold `rx` low for 4 ticks (868 clocks), then return it high. Required: no push, no error, FSM back in IDLE.
- **Parity check.** `PARITY`=2. Send 0x31 with parity bit 1, which is correct because 0x31 has three ones. Required: received as 0x31. Then send 0x31 with parity bit 0. Required: one `parity_err` pulse and `fifo_count` unchanged.
- **Framing error and break.** Send 0x55 with its stop bit low, then hold `rx` low for 3 bit times. Required: exactly one `frame_err`. Then send 0xA5 after `rx` returns high. Required: received as 0xA5.
- **FIFO overrun.** `rx_ready`=0. Send 9 frames 0x01 through 0x09. Required: `fifo_count`=8 and one `overrun` pulse on frame 9. Then raise `rx_ready`. Required: 0x01 through 0x08 drain in order, one per clock.
- **Reset mid-frame, and a 2-stop variant.** Assert `rst` low during DATA bit 3. Required: all outputs return to their reset values. Then, with `STOP_BITS`=2 and `DATA_BITS`=7, send 0x5A. Required: received correctly.
